// File: rtl/wire_unpacking_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : wire_unpacking_stream_if
// Brief    : Packed-word input stream and unpacked-lane output stream bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface wire_unpacking_stream_if #(
    parameter int LANES = 16,
    parameter int WIDTH = 32
);
    localparam int c_LANE_W = $clog2(LANES);

    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    in_data;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_data;
    logic [c_LANE_W-1:0] out_lane;
    logic                out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_lane, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_lane, out_last
    );
endinterface
`default_nettype wire

// File: rtl/wire_unpacking_stream.sv
`default_nettype none
// ============================================================================
// Module   : wire_unpacking_stream
// Brief    : Ping-pong transpose buffer rebuilding lane words from slice words.
// Revision : 1.0 - initial release
// ============================================================================
module wire_unpacking_stream #(
    parameter int LANES = 16,
    parameter int SLICE = 2,
    parameter int WIDTH = 32
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic                  abort,
    wire_unpacking_stream_if.slave     s
);
    localparam int                  c_CNT_W    = $clog2(LANES);
    localparam int                  c_BASE_W   = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0]  c_LAST_IDX = c_CNT_W'(LANES - 1);

    logic [WIDTH-1:0]    r_bank [2][LANES];
    logic                r_wr_bank;
    logic                r_rd_bank;
    logic [c_CNT_W-1:0]  r_wr_cnt;
    logic [c_CNT_W-1:0]  r_rd_cnt;
    logic [1:0]          r_full;

    logic                w_in_ready;
    logic                w_out_valid;
    logic                w_in_fire;
    logic                w_out_fire;
    logic [1:0]          w_full_next;
    logic [c_BASE_W-1:0] w_wr_base;
    logic [SLICE-1:0]    w_in_slice [LANES];

    // Lane j of the incoming word sits at bits [SLICE*j +: SLICE].
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign w_in_slice[j] = s.in_data[j*SLICE +: SLICE];
    end

    assign w_in_ready  = ~r_full[r_wr_bank];
    assign w_out_valid = r_full[r_rd_bank];
    assign w_in_fire   = s.in_valid & w_in_ready;
    assign w_out_fire  = w_out_valid & s.out_ready;
    assign w_wr_base   = c_BASE_W'(r_wr_cnt * SLICE);

    assign s.in_ready  = w_in_ready;
    assign s.out_valid = w_out_valid;
    assign s.out_data  = r_bank[r_rd_bank][r_rd_cnt];
    assign s.out_lane  = r_rd_cnt;
    assign s.out_last  = w_out_valid & (r_rd_cnt == c_LAST_IDX);

    // Fill and drain always target different banks, so set and clear never collide.
    always_comb begin
        w_full_next = r_full;
        if (w_out_fire && (r_rd_cnt == c_LAST_IDX)) begin
            w_full_next[r_rd_bank] = 1'b0;
        end
        if (w_in_fire && (r_wr_cnt == c_LAST_IDX)) begin
            w_full_next[r_wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_full    <= '0;
            for (int b = 0; b < 2; b++) begin
                for (int j = 0; j < LANES; j++) begin
                    r_bank[b][j] <= '0;
                end
            end
        end else if (abort) begin
            // Bank contents are left in place; clearing the full flags hides them.
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_full    <= '0;
        end else begin
            if (w_in_fire) begin
                for (int j = 0; j < LANES; j++) begin
                    r_bank[r_wr_bank][j][w_wr_base +: SLICE] <= w_in_slice[j];
                end
                if (r_wr_cnt == c_LAST_IDX) begin
                    r_wr_cnt  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_cnt  <= r_wr_cnt + 1'b1;
                end
            end
            if (w_out_fire) begin
                if (r_rd_cnt == c_LAST_IDX) begin
                    r_rd_cnt  <= '0;
                    r_rd_bank <= ~r_rd_bank;
                end else begin
                    r_rd_cnt  <= r_rd_cnt + 1'b1;
                end
            end
            r_full <= w_full_next;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_wire_unpacking_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_wire_unpacking_stream
// Brief    : Scoreboard bench for the slice-to-lane unpacker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wire_unpacking_stream;
    localparam int LANES = 16;
    localparam int WIDTH = 32;

    typedef logic [31:0] blk_t [16];
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  lane;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic abort;

    always #5 clk = ~clk;

    wire_unpacking_stream_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();

    wire_unpacking_stream #(.LANES(LANES), .SLICE(2), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .abort (abort),
        .s     (bus.slave)
    );

    exp_t        sb[$];
    exp_t        e_mon;
    int          total = 0;
    int          bad   = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [3:0]  prev_lane;
    logic        prev_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboard compare on every output handshake, plus hold checks while stalled.
    always @(negedge clk) begin
        if (prev_stall && reset) begin
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_data",  bus.out_data,  prev_data);
            chk("hold_lane",  bus.out_lane,  prev_lane);
            chk("hold_last",  bus.out_last,  prev_last);
        end
        if (reset && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                e_mon = sb.pop_front();
                chk("out_data", bus.out_data, e_mon.data);
                chk("out_lane", bus.out_lane, e_mon.lane);
                chk("out_last", bus.out_last, e_mon.last);
            end
        end
        prev_stall <= reset && bus.out_valid && !bus.out_ready;
        prev_data  <= bus.out_data;
        prev_lane  <= bus.out_lane;
        prev_last  <= bus.out_last;
    end

    // Reference packer: word k bits [2j+1:2j] = lane j bits [2k+1:2k].
    task automatic pack(input blk_t lanes, output blk_t words);
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 16; j++) begin
                words[k][2*j +: 2] = lanes[j][2*k +: 2];
            end
        end
    endtask

    task automatic push_block(input blk_t lanes);
        for (int j = 0; j < 16; j++) begin
            sb.push_back('{data: lanes[j], lane: 4'(j), last: (j == 15)});
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the word is accepted.
    task automatic send_word(input logic [31:0] d, output int waits);
        waits = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(negedge clk);
        while (!bus.in_ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input blk_t words, input blk_t lanes, input bit chk_lat,
                              output int waits_total);
        int w;
        waits_total = 0;
        push_block(lanes);
        for (int k = 0; k < 16; k++) begin
            send_word(words[k], w);
            waits_total += w;
            if (chk_lat && k == 14) chk("valid_before_16th", bus.out_valid, 0);
            if (chk_lat && k == 15) begin
                chk("valid_after_16th", bus.out_valid, 1);
                chk("first_lane", bus.out_lane, 0);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int c = 0;
        while ((sb.size() != 0 || bus.out_valid) && c < 300) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("drain_timeout", (c < 300), 1);
    endtask

    task automatic rand_block(output blk_t lanes);
        for (int j = 0; j < 16; j++) lanes[j] = $urandom();
    endtask

    initial begin
        blk_t lanes, words, l2, w2;
        int   wt, wsum, nready, cyc;

        reset = 1'b0;
        abort = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  bus.in_ready,  1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_lane",  bus.out_lane,  0);
        chk("rst_out_last",  bus.out_last,  0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Lane 0 only: every packed word carries 2'b11 in lane 0.
        bus.out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            words[k] = 32'h0000_0003;
            lanes[k] = (k == 0) ? 32'hFFFF_FFFF : 32'h0;
        end
        send_block(words, lanes, 1'b1, wt);
        wait_drain();

        // Slice 0 only: every lane gets 2'b11 in its lowest slice.
        for (int k = 0; k < 16; k++) begin
            words[k] = (k == 0) ? 32'hFFFF_FFFF : 32'h0;
            lanes[k] = 32'h0000_0003;
        end
        send_block(words, lanes, 1'b1, wt);
        wait_drain();

        // Round trip: 8 back-to-back random blocks with no input stall.
        wsum = 0;
        for (int b = 0; b < 8; b++) begin
            rand_block(lanes);
            pack(lanes, words);
            send_block(words, lanes, 1'b0, wt);
            wsum += wt;
        end
        chk("rt_in_stalls", wsum, 0);
        wait_drain();

        // Backpressure: two blocks fill both banks, third block must wait.
        bus.out_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            rand_block(lanes);
            pack(lanes, words);
            send_block(words, lanes, 1'b0, wt);
            chk("bp_fill_stalls", wt, 0);
        end
        rand_block(l2);
        pack(l2, w2);
        bus.in_valid = 1'b1;
        bus.in_data  = w2[0];
        nready = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.in_ready) nready++;
        end
        chk("bp_both_full_ready", nready, 0);
        chk("bp_out_valid", bus.out_valid, 1);
        chk("bp_out_lane", bus.out_lane, 0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        cyc = 0;
        while (!bus.in_ready && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("bp_release_cycles", cyc, 16);
        push_block(l2);
        for (int k = 0; k < 16; k++) send_word(w2[k], wt);
        bus.in_valid = 1'b0;
        wait_drain();

        // Abort after 7 words, with a junk word offered during the abort cycle.
        for (int k = 0; k < 7; k++) send_word($urandom(), wt);
        bus.in_data = $urandom();
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        bus.in_valid = 1'b0;
        chk("abort_in_ready",  bus.in_ready,  1);
        chk("abort_out_valid", bus.out_valid, 0);
        rand_block(lanes);
        pack(lanes, words);
        send_block(words, lanes, 1'b1, wt);
        wait_drain();

        // Asynchronous reset in the middle of a drain, at lane 5.
        bus.out_ready = 1'b0;
        rand_block(lanes);
        pack(lanes, words);
        send_block(words, lanes, 1'b0, wt);
        bus.out_ready = 1'b1;
        cyc = 0;
        while (bus.out_lane != 4'd5 && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("rst_reach_lane5", bus.out_lane, 5);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_in_ready",  bus.in_ready,  1);
        chk("midrst_out_lane",  bus.out_lane,  0);
        sb.delete();
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        rand_block(lanes);
        pack(lanes, words);
        send_block(words, lanes, 1'b1, wt);
        wait_drain();

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
`default_nettype wire
